instruction_memory_loader: RTL

- Writer side of the 256-word instruction memory.
- Receives a little-endian byte stream (e.g. from a UART receiver) and packs it into 32-bit words.
- Issues one-cycle word writes into instruction memory at consecutive word-aligned addresses.
- Holds the CPU while loading and reports completion plus an XOR checksum of the loaded program.

---
 rtl/instruction_memory_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_loader
// Brief    : Packs a little-endian byte stream into 32-bit words and writes
//            them to instruction memory, holding the CPU while it loads.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_loader #(
    parameter int          DEPTH_WORDS  = 256,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic [8:0]  loadLength,
    input  logic        abort,
    input  logic [7:0]  byteData,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        memWriteEnable,
    output logic [31:0] memWriteAddress,
    output logic [31:0] memWriteData,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] checksum,
    output logic [8:0]  wordsLoaded
);

    localparam logic [8:0] c_DEPTH = 9'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic [8:0]  r_word_idx;
    logic [8:0]  r_eff_len;
    logic        r_byte_ready;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_aborted;
    logic [31:0] r_checksum;
    logic [8:0]  r_words;

    logic [8:0]  w_eff_len;

    // Clamping the length here is what makes address wrap-around impossible.
    assign w_eff_len = (loadLength > c_DEPTH) ? c_DEPTH : loadLength;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_word       <= 32'd0;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= 9'd0;
            r_eff_len    <= 9'd0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_checksum   <= 32'd0;
            r_words      <= 9'd0;
        end else begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_eff_len  <= w_eff_len;
                        r_checksum <= 32'd0;
                        r_words    <= 9'd0;
                        r_aborted  <= 1'b0;
                        r_byte_idx <= 2'd0;
                        r_word_idx <= 9'd0;
                        r_busy     <= 1'b1;
                        if (w_eff_len == 9'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_RECEIVE;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                S_RECEIVE: begin
                    if (abort) begin
                        r_state      <= S_IDLE;
                        r_aborted    <= 1'b1;
                        r_busy       <= 1'b0;
                        r_byte_ready <= 1'b0;
                        r_byte_idx   <= 2'd0;
                    end else if (byteValid) begin
                        r_word[8*r_byte_idx +: 8] <= byteData;
                        r_byte_idx                <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_we         <= 1'b1;
                            r_addr       <= BASE_ADDRESS + {21'd0, r_word_idx, 2'b00};
                            r_wdata      <= {byteData, r_word[23:0]};
                        end
                    end
                end
                S_WRITE: begin
                    // The word being written always counts, even if abort arrives now.
                    r_checksum <= r_checksum ^ r_wdata;
                    r_words    <= r_words + 9'd1;
                    r_word_idx <= r_word_idx + 9'd1;
                    r_byte_idx <= 2'd0;
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (r_word_idx == r_eff_len - 9'd1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_RECEIVE;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_byte_ready <= 1'b0;
                end
            endcase
        end
    end

    assign byteReady       = r_byte_ready;
    assign memWriteEnable  = r_we;
    assign memWriteAddress = r_addr;
    assign memWriteData    = r_wdata;
    assign busy            = r_busy;
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign checksum        = r_checksum;
    assign wordsLoaded     = r_words;

endmodule
`default_nettype wire
